csa_accum: RTL and testbench
============================

# csa_accum

Streaming unsigned accumulator that consumes a row of 3:2 full-adder cells (`$fa`, mapped to `sky130_osu_sc_15T_hs__addf_1`). Running sums are held in carry-save form, so each input beat costs one full-adder delay with no carry chain. At the end of a frame, a chunked carry-propagate adder resolves the sum over several cycles. It sits directly downstream of the adder techmap and is the first platform block that puts the full-adder cells on a registered, timing-critical path.

## Interface
Parameters:
- `WIDTH`, default 16: input operand width; the operand is zero-extended.
- `ACC_WIDTH`, default 24: accumulator and result width; must be ≥ `WIDTH`.
- `CHUNK`, default 8: carry-propagate bits resolved per cycle.
- Derived: NCHUNK = ceil(`ACC_WIDTH`/`CHUNK`). The final chunk may be narrower than `CHUNK`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_data` in `WIDTH`: operand.
- `in_last` in 1: the beat is the last of its frame.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out `ACC_WIDTH`: frame sum.
- `out_overflow` out 1: the frame sum exceeded 2^`ACC_WIDTH`−1.

## Operation
States:
- **ACCUM**
  - `in_ready`=1.
  - On each accepted beat (`in_valid`&&`in_ready`), with D = zext(`in_data`): S ← S⊕C⊕D; C ← {maj(S,C,D)[ACC_WIDTH-2:0],1'b0}.
  - maj(S,C,D)[ACC_WIDTH-1]=1 sets sticky ovf. Values are non-negative, so any dropped carry is true overflow.
  - An accepted beat with `in_last`=1 → RESOLVE, chunk index k=0, carry cin=0.
- **RESOLVE**
  - `in_ready`=0.
  - Each cycle: R[k] = S[k]+C[k]+cin over chunk k; cin ← chunk carry-out; k ← k+1.
  - The carry-out of the final chunk ORs into ovf.
  - After chunk NCHUNK−1 → OUTPUT.
- **OUTPUT**
  - `out_valid`=1; `out_data`=R; `out_overflow`=ovf; `in_ready`=0.
  - On `out_valid`&&`out_ready`: S, C and ovf clear; → ACCUM.

Rules:
- Beats with `in_valid`=0 leave S and C unchanged; gaps are allowed.
- A single-beat frame (first beat carries `in_last`) is legal.
- All arithmetic is modulo 2^`ACC_WIDTH` before the saturation option is applied.
- The carry-save row is instantiated as `ACC_WIDTH` independent 3:2 cells so synthesis maps it to `addf`. Bits where C is constant 0 map to `addh`.

## Timing
- Reset:
  - While `rst` is high, at every edge: state=ACCUM, S=C=R=0, ovf=0.
  - Outputs during reset: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_overflow`=0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- Throughput: one beat per cycle in ACCUM.
- Latency:
  - `out_valid` asserts NCHUNK edges after the edge that accepts the `in_last` beat (3 with defaults).
  - The next frame's first beat can be accepted one cycle after the output handshake.
- Handshakes:
  - `out_data` and `out_overflow` are stable while `out_valid`&&!`out_ready`.
  - `out_valid` never drops without a handshake except on `rst`.
  - `in_ready` is 0 throughout RESOLVE and OUTPUT.
- Reset mid-frame or mid-RESOLVE discards all partial state; no result is emitted.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `in_*` or `out_ready` to any output.

## Configuration
- Macro: `CSA_ACCUM_SAT_EN`.
- **Defined:** when ovf=1 in OUTPUT, `out_data` = all ones (2^`ACC_WIDTH`−1); `out_overflow` still reports 1.
- **Undefined:** `out_data` is the wrapped sum modulo 2^`ACC_WIDTH`; `out_overflow` reports 1 on overflow.
- Handshake behaviour and latency are identical in both builds.

## Test plan
1. Reset, then beats 1, 2, 3 (last on 3) with `out_ready`=1 → `out_data`=0x000006, `out_overflow`=0, `out_valid` 3 edges after the last accept.
2. Single-beat frame `in_data`=0xABCD, `in_last`=1 → `out_data`=0x00ABCD. Check the carry ripples across chunks with 0xFFFF followed by 0x0001 → 0x010000.
3. 257 beats of 0xFFFF → `out_overflow`=1. `out_data`=0x00FEFF when `CSA_ACCUM_SAT_EN` is undefined; 0xFFFFFF when it is defined.
4. Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid`, `out_data` and `out_overflow` stay stable and `in_ready`=0. Raise `out_ready` → `in_ready`=1 on the next cycle and the new frame starts from 0.
5. Random `in_valid` gaps on beats 0x1234, 0x4321 (last) → 0x005555; idle cycles leave the sum unchanged.
6. Assert `rst` for 1 cycle during RESOLVE → no `out_valid`. A following frame with beat 0x0007 (last) → 0x000007, `out_overflow`=0.

Source files
------------

// File: rtl/csa_accum_if.sv
// Stream handshake bundle for csa_accum: operand input channel and frame-sum output channel.
interface csa_accum_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/csa_accum.sv
// Carry-save streaming accumulator with chunked carry-propagate resolve at frame end.
// Optional build macro CSA_ACCUM_SAT_EN saturates the reported sum on overflow.
module csa_accum #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CHUNK     = 8
) (
  input  logic        clk,
  input  logic        rst,
  csa_accum_if.slave  bus
);

  localparam int NCHUNK = (ACC_WIDTH + CHUNK - 1) / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LASTW  = ACC_WIDTH - (NCHUNK - 1) * CHUNK;

  typedef enum logic [1:0] {ST_ACCUM, ST_RESOLVE, ST_OUTPUT} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d, c_q, c_d, r_q, r_d;
  logic                 ovf_q, ovf_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 cin_q, cin_d;
  logic                 rdy_q, rdy_d;

  logic [ACC_WIDTH-1:0] d_ext, fa_s, fa_c;
  logic [CHUNK-1:0]     s_ch, c_ch;
  logic [CHUNK:0]       ch_sum;
  logic [ACC_WIDTH-1:0] ch_mask, ch_val, res;
  logic                 last_cout;
  int unsigned          sh;

  assign d_ext = ACC_WIDTH'(bus.in_data);

  // One independent 3:2 cell per bit; no carry ripples between cells.
  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_fa
    assign fa_s[i] = s_q[i] ^ c_q[i] ^ d_ext[i];
    assign fa_c[i] = (s_q[i] & c_q[i]) | (s_q[i] & d_ext[i]) | (c_q[i] & d_ext[i]);
  end

  // Chunk k of S and C; bits past ACC_WIDTH shift in as zero for a narrow final chunk.
  always_comb begin
    sh        = int'(k_q) * CHUNK;
    s_ch      = CHUNK'(s_q >> sh);
    c_ch      = CHUNK'(c_q >> sh);
    ch_sum    = {1'b0, s_ch} + {1'b0, c_ch} + {{CHUNK{1'b0}}, cin_q};
    ch_mask   = ACC_WIDTH'({CHUNK{1'b1}}) << sh;
    ch_val    = ACC_WIDTH'(ch_sum[CHUNK-1:0]) << sh;
    last_cout = |(ch_sum >> LASTW);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    cin_d   = cin_q;
    case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid && rdy_q) begin
          s_d   = fa_s;
          c_d   = {fa_c[ACC_WIDTH-2:0], 1'b0};
          ovf_d = ovf_q | fa_c[ACC_WIDTH-1];
          if (bus.in_last) begin
            state_d = ST_RESOLVE;
            k_d     = '0;
            cin_d   = 1'b0;
          end
        end
      end
      ST_RESOLVE: begin
        r_d   = (r_q & ~ch_mask) | ch_val;
        cin_d = ch_sum[CHUNK];
        k_d   = k_q + KW'(1);
        if (int'(k_q) == NCHUNK - 1) begin
          ovf_d   = ovf_q | last_cout;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          s_d     = '0;
          c_d     = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    rdy_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
      cin_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
      cin_q   <= cin_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef CSA_ACCUM_SAT_EN
  function automatic logic [ACC_WIDTH-1:0] sat_result(input logic [ACC_WIDTH-1:0] sum,
                                                      input logic ovf);
    return ovf ? '1 : sum;
  endfunction
  assign res = sat_result(r_q, ovf_q);
`else
  assign res = r_q;
`endif

  // in_ready is registered so it stays low through reset and drops with the last beat.
  assign bus.in_ready     = rdy_q;
  assign bus.out_valid    = (state_q == ST_OUTPUT);
  assign bus.out_data     = (state_q == ST_OUTPUT) ? res : '0;
  assign bus.out_overflow = (state_q == ST_OUTPUT) & ovf_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed-vector bench for csa_accum with hand-computed frame sums.
module tb_csa_accum;
  logic clk, rst;
  int   total, bad;

  csa_accum_if #(.WIDTH(16), .ACC_WIDTH(24)) bus ();

  csa_accum #(.WIDTH(16), .ACC_WIDTH(24), .CHUNK(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

`ifdef CSA_ACCUM_SAT_EN
  localparam logic [23:0] OVF_EXP = 24'hFFFFFF;
`else
  localparam logic [23:0] OVF_EXP = 24'h00FEFF;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(output logic [23:0] d, output logic o, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) check("out_timeout", 32'd0, 32'd1);
    d = bus.out_data;
    o = bus.out_overflow;
  endtask

  task automatic frame_check(input string tag, input logic [23:0] exp_d, input logic exp_o);
    logic [23:0] d;
    logic        o;
    int          lat;
    get_result(d, o, lat);
    check({tag, "_data"}, 32'(d), 32'(exp_d));
    check({tag, "_ovf"}, 32'(o), 32'(exp_o));
    check({tag, "_lat"}, 32'(lat), 32'd3);
    @(negedge clk);
    check({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [23:0] d0;
    logic        o0;
    int          lat, seen;
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ovf", 32'(bus.out_overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(bus.in_ready), 32'd1);

    // 1 + 2 + 3
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b1);
    frame_check("sum123", 24'h000006, 1'b0);

    beat(16'hABCD, 1'b1);
    frame_check("single", 24'h00ABCD, 1'b0);

    beat(16'hFFFF, 1'b0);
    beat(16'h0001, 1'b1);
    frame_check("ripple", 24'h010000, 1'b0);

    // 257 * 0xFFFF = 0x100FEFF
    for (int i = 0; i < 257; i++) beat(16'hFFFF, i == 256);
    frame_check("ovf", OVF_EXP, 1'b1);

    // Backpressure
    bus.out_ready = 1'b0;
    beat(16'd5, 1'b1);
    get_result(d0, o0, lat);
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", 32'(bus.out_data), 32'h5);
      check("bp_ovf", 32'(bus.out_overflow), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    check("bp_release_vld", 32'(bus.out_valid), 32'd0);
    beat(16'd9, 1'b1);
    frame_check("after_bp", 24'h000009, 1'b0);

    // Gaps with garbage on the data bus while idle
    beat(16'h1234, 1'b0);
    bus.in_data = 16'hFFFF;
    repeat (3) @(negedge clk);
    beat(16'h4321, 1'b0 == 1'b1);
    bus.in_data = 16'hFFFF;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0000;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    frame_check("gaps", 24'h005555, 1'b0);

    // Reset during RESOLVE
    beat(16'h00FF, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_out", 32'(seen), 32'd0);
    beat(16'h0007, 1'b1);
    frame_check("post_rst", 24'h000007, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
